seq_det_prog: RTL and testbench

SEQ_DET_PROG -- requirements
Module: seq_det_prog

---
 rtl/seq_det_prog.sv | 169 ++++++++++++++++
 tb/tb_seq_det_prog.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_prog
// Purpose  : Programmable serial sequence detector. A pattern of 1..MAXLEN
//            bits is loaded at run time. The MSB-first DIN stream is shifted
//            into a history register, and MATCH pulses for one cycle after
//            the final pattern bit arrives. Overlapping matches can be
//            enabled or disabled.
// Options  : define SEQ_DET_CNT_EN to build the saturating match counter
//            (COUNT). When it is undefined, COUNT is tied to zero and no
//            counter flops exist.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_prog #(
  parameter int MAXLEN = 16,  // maximum pattern length, 2..32
  parameter int LENW   = 5,   // width of LEN; must hold MAXLEN
  parameter int CNTW   = 8    // match counter width
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              LOAD,
  input  logic [MAXLEN-1:0] PAT,
  input  logic [LENW-1:0]   LEN,
  input  logic              OVERLAP,
  input  logic              DIN,
  input  logic              DVALID,
  output logic              MATCH,
  output logic              ERR,
  output logic              ARMED,
  output logic [CNTW-1:0]   COUNT
);

  localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

  typedef enum logic [0:0] {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [MAXLEN-1:0] hist, hist_next;
  logic [MAXLEN-1:0] pat_reg, pat_next;
  logic [LENW-1:0]   len_reg, len_next;
  logic [LENW-1:0]   fill, fill_next;
  logic              match_reg, match_next;
  logic              err_reg, err_next;

  logic              len_legal;
  logic [MAXLEN-1:0] len_mask;
  logic [MAXLEN-1:0] hist_shift;
  logic [LENW-1:0]   fill_inc;
  logic              consume;
  logic              hit;

  // A LOAD is only accepted when 1 <= LEN <= MAXLEN.
  assign len_legal = (LEN != '0) && (LEN <= MAXLEN_L);

  // Mask covering the LEN_reg least significant history bits. Only these
  // bits take part in the comparison.
  for (genvar i = 0; i < MAXLEN; i++) begin : g_mask
    assign len_mask[i] = (len_reg > LENW'(i));
  end

  // The history as it would be after consuming DIN. The newest bit is the LSB.
  assign hist_shift = {hist[MAXLEN-2:0], DIN};

  // Fill count after consuming DIN. It saturates at MAXLEN.
  assign fill_inc = (fill == MAXLEN_L) ? fill : fill + 1'b1;

  // A bit is consumed only in RUN, with DVALID set, and when neither CLR nor
  // LOAD claims the cycle.
  assign consume = (state == ST_RUN) && DVALID && !CLR && !LOAD;

  // A hit needs enough fresh bits, and the newest LEN bits must equal the
  // pattern. Requiring fill >= LEN keeps stale history bits out of the match.
  assign hit = consume && (fill_inc >= len_reg) &&
               (((hist_shift ^ pat_reg) & len_mask) == '0);

  // State, configuration and history registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_UNCFG;
      hist      <= '0;
      pat_reg   <= '0;
      len_reg   <= '0;
      fill      <= '0;
      match_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state     <= state_next;
      hist      <= hist_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      fill      <= fill_next;
      match_reg <= match_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and datapath decode. Priority order is CLR, then LOAD, then DVALID.
  always_comb begin
    state_next = state;
    hist_next  = hist;
    pat_next   = pat_reg;
    len_next   = len_reg;
    fill_next  = fill;
    match_next = 1'b0;
    err_next   = 1'b0;

    if (CLR) begin
      // Clear the stream state and keep the configuration.
      hist_next = '0;
      fill_next = '0;
    end else if (LOAD) begin
      if (len_legal) begin
        pat_next   = PAT;
        len_next   = LEN;
        hist_next  = '0;
        fill_next  = '0;
        state_next = ST_RUN;
      end else begin
        // An illegal length only raises ERR. Nothing else changes.
        err_next = 1'b1;
      end
    end else begin
      case (state)
        ST_UNCFG: begin
          // No pattern is loaded yet, so DIN is ignored.
        end
        ST_RUN: begin
          if (DVALID) begin
            hist_next  = hist_shift;
            // In non-overlapping mode a hit restarts the fill, so the next
            // match needs LEN fresh bits.
            fill_next  = (hit && !OVERLAP) ? '0 : fill_inc;
            match_next = hit;
          end
        end
        default: state_next = ST_UNCFG;
      endcase
    end
  end

  assign MATCH = match_reg;
  assign ERR   = err_reg;
  assign ARMED = (state == ST_RUN);

`ifdef SEQ_DET_CNT_EN
  logic [CNTW-1:0] count_reg;

  // Saturating hit counter. CLR zeroes it; LOAD leaves it unchanged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_reg <= '0;
    end else if (CLR) begin
      count_reg <= '0;
    end else if (hit && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign COUNT = count_reg;
`else
  assign COUNT = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_prog
// Purpose  : Self-checking bench for seq_det_prog. Runs directed scenarios
//            and then random traffic. Results are compared against a
//            queue-based reference model of the detector.
//            A second instance with CNTW=2 exercises counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_prog;

  localparam int MAXLEN = 16;
  localparam int LENW   = 5;
  localparam int CNTW   = 8;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST, CLR, LOAD, OVERLAP, DIN, DVALID;
  logic [MAXLEN-1:0] PAT;
  logic [LENW-1:0]   LEN;
  logic              MATCH, ERR, ARMED;
  logic [CNTW-1:0]   COUNT;
  logic              match_s, err_s, armed_s;
  logic [1:0]        count_s;

  seq_det_prog #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .LOAD(LOAD), .PAT(PAT), .LEN(LEN),
    .OVERLAP(OVERLAP), .DIN(DIN), .DVALID(DVALID),
    .MATCH(MATCH), .ERR(ERR), .ARMED(ARMED), .COUNT(COUNT)
  );

  seq_det_prog #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(2)) dut_sat (
    .CLK(CLK), .RST(RST), .CLR(CLR), .LOAD(LOAD), .PAT(PAT), .LEN(LEN),
    .OVERLAP(OVERLAP), .DIN(DIN), .DVALID(DVALID),
    .MATCH(match_s), .ERR(err_s), .ARMED(armed_s), .COUNT(count_s)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int match_seen = 0;
  int err_seen   = 0;

  // Reference model. The history is a queue of consumed bits, oldest first.
  // Its size is the fill level.
  bit                hist_q[$];
  logic [MAXLEN-1:0] m_pat;
  int                m_len;
  bit                m_armed, m_match, m_err;
  int                m_hits;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int exp_count(input int maxv);
    if (!CNT_ON) return 0;
    return (m_hits > maxv) ? maxv : m_hits;
  endfunction

  function automatic bit tail_matches();
    int n = hist_q.size();
    for (int k = 0; k < m_len; k++)
      if (hist_q[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    hist_q.delete();
    m_pat = '0; m_len = 0; m_armed = 0; m_match = 0; m_err = 0; m_hits = 0;
  endfunction

  function automatic void model_step();
    m_match = 0;
    m_err   = 0;
    if (CLR) begin
      hist_q.delete();
      m_hits = 0;
    end else if (LOAD) begin
      if (int'(LEN) == 0 || int'(LEN) > MAXLEN) m_err = 1;
      else begin
        m_pat = PAT; m_len = int'(LEN); m_armed = 1; hist_q.delete();
      end
    end else if (DVALID && m_armed) begin
      hist_q.push_back(DIN);
      if (hist_q.size() > MAXLEN) void'(hist_q.pop_front());
      if (hist_q.size() >= m_len && tail_matches()) begin
        m_match = 1;
        m_hits++;
        if (!OVERLAP) hist_q.delete();
      end
    end
  endfunction

  task automatic check_outputs(input string pfx);
    check_eq({pfx, "_match"}, 32'(MATCH), 32'(m_match));
    check_eq({pfx, "_err"},   32'(ERR),   32'(m_err));
    check_eq({pfx, "_armed"}, 32'(ARMED), 32'(m_armed));
    check_eq({pfx, "_count"}, 32'(COUNT), 32'(exp_count(2**CNTW - 1)));
    check_eq({pfx, "_s_match"}, 32'(match_s), 32'(m_match));
    check_eq({pfx, "_s_err"},   32'(err_s),   32'(m_err));
    check_eq({pfx, "_s_armed"}, 32'(armed_s), 32'(m_armed));
    check_eq({pfx, "_s_count"}, 32'(count_s), 32'(exp_count(3)));
  endtask

  // One clock: the model consumes the inputs sampled at the edge, then the
  // outputs are checked 1ns later.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_outputs("cyc");
    if (MATCH) match_seen++;
    if (ERR)   err_seen++;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1; CLR = 0; LOAD = 0; DVALID = 0;
    #1;
    model_reset();
    check_outputs("rst");
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic send_bit(input logic b);
    DIN = b; DVALID = 1; LOAD = 0; CLR = 0;
    tick();
    DVALID = 0;
  endtask

  task automatic load_cfg(input logic [MAXLEN-1:0] p, input int l, input logic ov);
    PAT = p; LEN = LENW'(l); OVERLAP = ov; LOAD = 1; CLR = 0; DVALID = 0;
    tick();
    LOAD = 0;
  endtask

  task automatic idle(input int n);
    DVALID = 0; LOAD = 0; CLR = 0;
    repeat (n) tick();
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  initial begin
    RST = 1; CLR = 0; LOAD = 0; OVERLAP = 0; DIN = 0; DVALID = 0;
    PAT = '0; LEN = '0;
    model_reset();
    #2;
    check_outputs("init");
    @(negedge CLK);
    RST = 0;

    // The 8-bit pattern 0xD3 produces a single match after its eighth bit.
    load_cfg(16'h00D3, 8, 1'b0);
    match_seen = 0;
    send_seq(32'b1101001, 7);
    check_eq("d3_no_early", 32'(match_seen), 32'd0);
    send_bit(1'b1);
    check_eq("d3_match_after_8th", 32'(MATCH), 32'd1);
    check_eq("d3_count", 32'(COUNT), CNT_ON ? 32'd1 : 32'd0);
    idle(1);
    check_eq("d3_pulses", 32'(match_seen), 32'd1);

    // The 3-bit pattern 101 gives two matches with overlap and one without.
    load_cfg(16'h0005, 3, 1'b1);
    match_seen = 0;
    send_seq(32'b10101, 5);
    idle(1);
    check_eq("ov1_pulses", 32'(match_seen), 32'd2);
    load_cfg(16'h0005, 3, 1'b0);
    match_seen = 0;
    send_seq(32'b10101, 5);
    idle(1);
    check_eq("ov0_pulses", 32'(match_seen), 32'd1);

    // A DVALID gap in the middle of the pattern 1101.
    load_cfg(16'h000D, 4, 1'b0);
    match_seen = 0;
    send_seq(32'b110, 3);
    idle(5);
    check_eq("gap_none", 32'(match_seen), 32'd0);
    send_bit(1'b1);
    idle(1);
    check_eq("gap_pulses", 32'(match_seen), 32'd1);

    // Illegal lengths raise ERR and never arm the detector.
    do_reset();
    err_seen = 0; match_seen = 0;
    load_cfg(16'h0001, 0, 1'b0);
    load_cfg(16'h0001, MAXLEN + 1, 1'b0);
    check_eq("illegal_err_pulses", 32'(err_seen), 32'd2);
    check_eq("illegal_armed", 32'(ARMED), 32'd0);
    send_seq(32'hFFFF_FFFF, 8);
    check_eq("illegal_no_match", 32'(match_seen), 32'd0);

    // A reset in mid-stream aborts the partial match.
    load_cfg(16'h00D3, 8, 1'b0);
    send_seq(32'b1101001, 7);
    do_reset();
    match_seen = 0;
    load_cfg(16'h00D3, 8, 1'b0);
    send_bit(1'b1);
    idle(1);
    check_eq("rst_abort_pulses", 32'(match_seen), 32'd0);
    check_eq("rst_abort_count", 32'(COUNT), 32'd0);

    // Five hits: the CNTW=2 counter saturates at 3.
    do_reset();
    load_cfg(16'h0001, 1, 1'b1);
    match_seen = 0;
    send_seq(32'b11111, 5);
    check_eq("sat_count2", 32'(count_s), CNT_ON ? 32'd3 : 32'd0);
    check_eq("sat_count8", 32'(COUNT), CNT_ON ? 32'd5 : 32'd0);
    check_eq("sat_pulses", 32'(match_seen), 32'd5);

    // A full-length pattern checks the MAXLEN boundary.
    load_cfg(16'hA5C3, MAXLEN, 1'b1);
    match_seen = 0;
    send_seq(32'h0000_A5C3, 16);
    idle(1);
    check_eq("full_len_pulses", 32'(match_seen), 32'd1);

    // Random traffic that mixes CLR, LOAD, DVALID and OVERLAP.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int l;
      CLR     = ($urandom_range(0, 99) < 2);
      LOAD    = ($urandom_range(0, 99) < 4);
      DVALID  = ($urandom_range(0, 99) < 80);
      OVERLAP = 1'($urandom_range(0, 1));
      DIN     = 1'($urandom_range(0, 1));
      PAT     = MAXLEN'($urandom);
      case ($urandom_range(0, 9))
        0:       l = $urandom_range(MAXLEN + 1, 31);
        1:       l = 0;
        2:       l = $urandom_range(5, MAXLEN);
        default: l = $urandom_range(1, 4);
      endcase
      LEN = LENW'(l);
      tick();
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
